// File: rtl/score_keeper.sv
// score_keeper: Dino game state machine and 3-digit BCD score, advanced by VGA frame ticks.
// Optional high-score register built only when SCORE_HISCORE_EN is defined.
module score_keeper #(
    parameter int FRAMES_PER_POINT = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync_n,
    input  logic       start,
    input  logic       collision,
    output logic [3:0] score_d0,
    output logic [3:0] score_d1,
    output logic [3:0] score_d2,
    output logic [3:0] hi_d0,
    output logic [3:0] hi_d1,
    output logic [3:0] hi_d2,
    output logic [1:0] state,
    output logic       milestone
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_POINT - 1);

    state_t     state_q, state_d;
    logic       vs_q, vs_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] d0_q, d1_q, d2_q;
    logic [3:0] d0_d, d1_d, d2_d;
    logic       milestone_q, milestone_d;

    logic       frame_tick;
    logic       at_max;
    logic [3:0] inc_d0, inc_d1, inc_d2;

    assign vs_d       = vsync_n;
    assign frame_tick = vs_q & ~vsync_n;
    assign at_max     = (d2_q == 4'd9) && (d1_q == 4'd9) && (d0_q == 4'd9);

    // BCD +1 with ripple carry; only applied when below 999
    always_comb begin
        inc_d0 = (d0_q == 4'd9) ? 4'd0 : d0_q + 4'd1;
        inc_d1 = d1_q;
        inc_d2 = d2_q;
        if (d0_q == 4'd9) begin
            inc_d1 = (d1_q == 4'd9) ? 4'd0 : d1_q + 4'd1;
            if (d1_q == 4'd9)
                inc_d2 = d2_q + 4'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        d0_d        = d0_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        milestone_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d     = ST_RUN;
                    frame_cnt_d = 8'd0;
                    d0_d        = 4'd0;
                    d1_d        = 4'd0;
                    d2_d        = 4'd0;
                end
            end
            ST_RUN: begin
                if (collision) begin
                    state_d = ST_OVER;
                end else if (frame_tick) begin
                    if (frame_cnt_q == LAST_FRAME) begin
                        frame_cnt_d = 8'd0;
                        if (!at_max) begin
                            d0_d        = inc_d0;
                            d1_d        = inc_d1;
                            d2_d        = inc_d2;
                            milestone_d = (inc_d1 == 4'd0) && (inc_d0 == 4'd0);
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            vs_q        <= 1'b1;
            frame_cnt_q <= 8'd0;
            d0_q        <= 4'd0;
            d1_q        <= 4'd0;
            d2_q        <= 4'd0;
            milestone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= vs_d;
            frame_cnt_q <= frame_cnt_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            milestone_q <= milestone_d;
        end
    end

    assign score_d0  = d0_q;
    assign score_d1  = d1_q;
    assign score_d2  = d2_q;
    assign state     = state_q;
    assign milestone = milestone_q;

`ifdef SCORE_HISCORE_EN
    logic [3:0] hi0_q, hi1_q, hi2_q;
    logic [3:0] hi0_d, hi1_d, hi2_d;
    logic       score_gt_hi;

    // Packed BCD digits compare correctly as a plain unsigned number
    assign score_gt_hi = {d2_q, d1_q, d0_q} > {hi2_q, hi1_q, hi0_q};

    always_comb begin
        hi0_d = hi0_q;
        hi1_d = hi1_q;
        hi2_d = hi2_q;
        if (state_q == ST_RUN && collision && score_gt_hi) begin
            hi0_d = d0_q;
            hi1_d = d1_q;
            hi2_d = d2_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi0_q <= 4'd0;
            hi1_q <= 4'd0;
            hi2_q <= 4'd0;
        end else begin
            hi0_q <= hi0_d;
            hi1_q <= hi1_d;
            hi2_q <= hi2_d;
        end
    end

    assign hi_d0 = hi0_q;
    assign hi_d1 = hi1_q;
    assign hi_d2 = hi2_q;
`else
    assign hi_d0 = 4'd0;
    assign hi_d1 = 4'd0;
    assign hi_d2 = 4'd0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Randomized bench for score_keeper: integer-score reference model checked every cycle,
// plus directed literal checks on reset, milestones, saturation, collision and async reset.
module tb_score_keeper;

    localparam int FPP = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync_n;
    logic       start;
    logic       collision;
    logic [3:0] score_d0, score_d1, score_d2;
    logic [3:0] hi_d0, hi_d1, hi_d2;
    logic [1:0] state;
    logic       milestone;

    score_keeper #(.FRAMES_PER_POINT(FPP)) dut (
        .clk       (clk),
        .reset     (reset),
        .vsync_n   (vsync_n),
        .start     (start),
        .collision (collision),
        .score_d0  (score_d0),
        .score_d1  (score_d1),
        .score_d2  (score_d2),
        .hi_d0     (hi_d0),
        .hi_d1     (hi_d1),
        .hi_d2     (hi_d2),
        .state     (state),
        .milestone (milestone)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: score and hi as plain integers 0..999
    int m_state = 0;
    int m_score = 0;
    int m_hi    = 0;
    int m_cnt   = 0;
    bit m_ms    = 1'b0;
    bit m_vs    = 1'b1;
    bit m_tick;
    bit hi_en;

    initial begin
`ifdef SCORE_HISCORE_EN
        hi_en = 1'b1;
`else
        hi_en = 1'b0;
`endif
    end

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0; m_score = 0; m_hi = 0; m_cnt = 0; m_ms = 1'b0; m_vs = 1'b1;
        end else begin
            m_tick = m_vs && !vsync_n;
            m_ms   = 1'b0;
            if (m_state == 1) begin
                if (collision) begin
                    m_state = 2;
                    if (hi_en && m_score > m_hi) m_hi = m_score;
                end else if (m_tick) begin
                    if (m_cnt == FPP - 1) begin
                        m_cnt = 0;
                        if (m_score < 999) begin
                            m_score = m_score + 1;
                            m_ms = (m_score % 100 == 0);
                        end
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
            end else if (start) begin
                m_state = 1; m_score = 0; m_cnt = 0;
            end
            m_vs = vsync_n;
        end
    end

    always @(negedge clk) begin
        chk("state", 32'(state), 32'(m_state));
        chk("score", 32'({score_d2, score_d1, score_d0}), 32'(to_bcd(m_score)));
        chk("hi", 32'({hi_d2, hi_d1, hi_d0}), 32'(to_bcd(m_hi)));
        chk("milestone", 32'(milestone), 32'(m_ms));
    end

    task automatic cyc(input bit vs, input bit st, input bit col);
        @(negedge clk);
        vsync_n   = vs;
        start     = st;
        collision = col;
    endtask

    // One frame: vsync low for 1-2 cycles, then high for 1-3 cycles
    task automatic frame();
        int lo, hi;
        lo = $urandom_range(1, 2);
        hi = $urandom_range(1, 3);
        for (int i = 0; i < lo; i++) cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < hi; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic run_until(input int s, input int c);
        for (int i = 0; i < 8000; i++) begin
            if (m_state == 1 && m_score == s && m_cnt == c) return;
            frame();
        end
        chk("run_until_timeout", 32'(m_score), 32'(s));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; vsync_n = 1'b1; start = 1'b0; collision = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    int ms_seen;

    initial begin
        reset = 1'b1; vsync_n = 1'b1; start = 1'b0; collision = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_score", 32'({score_d2, score_d1, score_d0}), 32'd0);
        chk("reset_ms", 32'(milestone), 32'd0);
        reset = 1'b0;

        // Collision in IDLE is ignored
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("idle_collision_state", 32'(state), 32'd0);

        // Start, then 12 frames -> 002
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("start_state", 32'(state), 32'd1);
        for (int i = 0; i < 12; i++) frame();
        chk("twelve_frames_score", 32'({score_d2, score_d1, score_d0}), 32'h002);
        chk("twelve_frames_state", 32'(state), 32'd1);

        // Start during RUN is ignored
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("run_start_score", 32'({score_d2, score_d1, score_d0}), 32'h002);

        // 099 -> 100 with a one-cycle milestone in cycle N+1
        run_until(99, 0);
        for (int i = 0; i < FPP - 1; i++) frame();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("ms_n_plus_1", 32'(milestone), 32'd1);
        chk("score_100", 32'({score_d2, score_d1, score_d0}), 32'h100);
        cyc(1'b1, 1'b0, 1'b0);
        chk("ms_n_plus_2", 32'(milestone), 32'd0);

        // Saturate at 999: 30 further frames, no milestone
        run_until(999, 0);
        ms_seen = 0;
        for (int i = 0; i < 30 * 3; i++) begin
            cyc((i % 3) != 0, 1'b0, 1'b0);
            if (milestone) ms_seen++;
        end
        chk("sat_score", 32'({score_d2, score_d1, score_d0}), 32'h999);
        chk("sat_ms_count", 32'(ms_seen), 32'd0);

        // Collision coinciding with the scoring tick at 041
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        run_until(41, FPP - 1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("col_state", 32'(state), 32'd2);
        chk("col_score", 32'({score_d2, score_d1, score_d0}), 32'h041);
        chk("col_hi", 32'({hi_d2, hi_d1, hi_d0}), hi_en ? 32'h041 : 32'h000);

        // Collision in OVER is ignored
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("over_collision_state", 32'(state), 32'd2);

        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("restart_score", 32'({score_d2, score_d1, score_d0}), 32'h000);
        chk("restart_hi", 32'({hi_d2, hi_d1, hi_d0}), hi_en ? 32'h041 : 32'h000);

        run_until(17, 2);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("lower_hi_kept", 32'({hi_d2, hi_d1, hi_d0}), hi_en ? 32'h041 : 32'h000);

        // Randomized phase
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4000; i++)
            cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 59) == 0),
                1'($urandom_range(0, 299) == 0));

        // Asynchronous reset between edges at 057
        cyc(1'b1, 1'b0, 1'b0);
        if (m_state != 1) cyc(1'b1, 1'b1, 1'b0);
        run_until(57, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("areset_state", 32'(state), 32'd0);
        chk("areset_score", 32'({score_d2, score_d1, score_d0}), 32'h000);
        chk("areset_hi", 32'({hi_d2, hi_d1, hi_d0}), 32'h000);
        chk("areset_ms", 32'(milestone), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) cyc(1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
